// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DATA_SIZE_DEF    = 32;
  localparam int ADDRESS_SIZE_DEF = 5;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from two valids, pointer moves
// past the winner on each advance strobe.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = rr_ptr_q ? 2'b10 : 2'b01;
    end
    // ALU winning hands priority to LSU and vice versa
    rr_ptr_d = advance ? grant[REQ_ALU] : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with one-entry staging register.
// Optional read bypass enabled by REGFILE_WB_ARB_BYPASS_EN.
//   state    | meaning
//   ST_IDLE  | stage empty
//   ST_ISSUE | stage valid, RegWEn driven
//   ST_HOLD  | stage valid, wr_hold high, RegWEn low
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_SIZE    = DATA_SIZE_DEF,
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_hold,
  input  logic                    req0_valid,
  input  logic                    req1_valid,
  output logic                    req0_ready,
  output logic                    req1_ready,
  input  logic [ADDRESS_SIZE-1:0] req0_addr,
  input  logic [ADDRESS_SIZE-1:0] req1_addr,
  input  logic [DATA_SIZE-1:0]    req0_data,
  input  logic [DATA_SIZE-1:0]    req1_data,
  output logic                    RegWEn,
  output logic [ADDRESS_SIZE-1:0] AddrD,
  output logic [DATA_SIZE-1:0]    DataD,
  output logic                    busy,
  input  logic [ADDRESS_SIZE-1:0] AddrA,
  input  logic [ADDRESS_SIZE-1:0] AddrB,
  input  logic [DATA_SIZE-1:0]    DataA_rf,
  input  logic [DATA_SIZE-1:0]    DataB_rf,
  output logic [DATA_SIZE-1:0]    DataA,
  output logic [DATA_SIZE-1:0]    DataB
);

  wb_state_e               state_q, state_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;
  logic                    reg_wen_q, reg_wen_d;
  logic [1:0]              grant;
  logic                    can_accept;
  logic                    accept;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    can_accept = (state_q == ST_IDLE) || ((state_q == ST_ISSUE) && !wr_hold);
    accept     = can_accept && (grant != 2'b00);
    req0_ready = can_accept && grant[REQ_ALU];
    req1_ready = can_accept && grant[REQ_LSU];
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    if (accept) begin
      state_d = wr_hold ? ST_HOLD : ST_ISSUE;
      if (grant[REQ_LSU]) begin
        addr_d = req1_addr;
        data_d = req1_data;
      end else begin
        addr_d = req0_addr;
        data_d = req0_data;
      end
    end else begin
      case (state_q)
        ST_ISSUE: state_d = wr_hold ? ST_HOLD : ST_IDLE;
        ST_HOLD:  state_d = wr_hold ? ST_HOLD : ST_ISSUE;
        default:  state_d = ST_IDLE;
      endcase
    end
    // Pre-computed so RegWEn leaves a flop; equals ISSUE && !wr_hold_q && AddrD!=0
    reg_wen_d = (state_d == ST_ISSUE) && !wr_hold && (addr_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      reg_wen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      reg_wen_q <= reg_wen_d;
    end
  end

  assign RegWEn = reg_wen_q;
  assign AddrD  = addr_q;
  assign DataD  = data_q;
  assign busy   = (state_q != ST_IDLE);

`ifdef REGFILE_WB_ARB_BYPASS_EN
  assign DataA = (busy && (AddrD == AddrA) && (AddrA != '0)) ? DataD : DataA_rf;
  assign DataB = (busy && (AddrD == AddrB) && (AddrB != '0)) ? DataD : DataB_rf;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{AddrA, AddrB};
  assign DataA = DataA_rf;
  assign DataB = DataB_rf;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table plus commit scoreboard.
module tb_regfile_wb_arbiter;

  localparam logic [31:0] RF_A = 32'h0000_0000;
  localparam logic [31:0] RF_B = 32'h5A5A_5A5A;
`ifdef REGFILE_WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_hold = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        RegWEn, busy;
  logic [4:0]  AddrD;
  logic [31:0] DataD;
  logic [4:0]  AddrA = 5'd31, AddrB = 5'd31;
  logic [31:0] DataA_rf = RF_A, DataB_rf = RF_B;
  logic [31:0] DataA, DataB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_hold    (wr_hold),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_addr  (req0_addr),
    .req1_addr  (req1_addr),
    .req0_data  (req0_data),
    .req1_data  (req1_data),
    .RegWEn     (RegWEn),
    .AddrD      (AddrD),
    .DataD      (DataD),
    .busy       (busy),
    .AddrA      (AddrA),
    .AddrB      (AddrB),
    .DataA_rf   (DataA_rf),
    .DataB_rf   (DataB_rf),
    .DataA      (DataA),
    .DataB      (DataB)
  );

  typedef struct {
    logic        hold;
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        r0;
    logic        r1;
    logic [31:0] xda;
    logic [31:0] xdb;
    logic        wen;
    logic        busy;
    logic [4:0]  xaddr;
    logic [31:0] xdata;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic hold,
                              input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic r0, input logic r1,
                              input logic wen, input logic bsy,
                              input logic [4:0] xa, input logic [31:0] xd,
                              input logic [4:0] ra = 5'd31, input logic [4:0] rb = 5'd31,
                              input logic [31:0] xda = 32'h0000_0000,
                              input logic [31:0] xdb = 32'h5A5A_5A5A);
    vec_t t;
    t.hold = hold; t.v0 = v0; t.a0 = a0; t.d0 = d0;
    t.v1 = v1; t.a1 = a1; t.d1 = d1; t.ra = ra; t.rb = rb;
    t.r0 = r0; t.r1 = r1; t.xda = xda; t.xdb = xdb;
    t.wen = wen; t.busy = bsy; t.xaddr = xa; t.xdata = xd;
    return t;
  endfunction

  // Every commit seen on the write port must match the oldest accepted write
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && RegWEn) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write: got addr %h data %h expected no write", AddrD, DataD);
      end else begin
        e = sb.pop_front();
        chk("sb_addr", {27'd0, AddrD}, {27'd0, e.a});
        chk("sb_data", DataD, e.d);
      end
    end
  end

  task automatic apply(input int i, input vec_t t);
    wr_hold    = t.hold;
    req0_valid = t.v0; req0_addr = t.a0; req0_data = t.d0;
    req1_valid = t.v1; req1_addr = t.a1; req1_data = t.d1;
    AddrA      = t.ra; AddrB = t.rb;
    #1;
    chk($sformatf("row%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, t.r0});
    chk($sformatf("row%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, t.r1});
    chk($sformatf("row%0d DataA", i), DataA, t.xda);
    chk($sformatf("row%0d DataB", i), DataB, t.xdb);
    if (t.r0 && t.v0 && t.a0 != 5'd0) sb.push_back('{t.a0, t.d0});
    if (t.r1 && t.v1 && t.a1 != 5'd0) sb.push_back('{t.a1, t.d1});
    @(negedge clk);
    chk($sformatf("row%0d RegWEn", i), {31'd0, RegWEn}, {31'd0, t.wen});
    chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, t.busy});
    if (t.busy) begin
      chk($sformatf("row%0d AddrD", i), {27'd0, AddrD}, {27'd0, t.xaddr});
      chk($sformatf("row%0d DataD", i), DataD, t.xdata);
    end
  endtask

  initial begin
    // hold v0 a0 d0 | v1 a1 d1 | r0 r1 | wen busy AddrD DataD | ra rb xda xdb
    vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h11,        1, 2, 32'h22,        1, 0, 1, 1, 1, 32'h11));
    vecs.push_back(mk(0, 1, 1, 32'h11,        1, 2, 32'h22,        0, 1, 1, 1, 2, 32'h22));
    vecs.push_back(mk(0, 1, 1, 32'h11,        1, 2, 32'h22,        1, 0, 1, 1, 1, 32'h11));
    vecs.push_back(mk(0, 1, 1, 32'h11,        1, 2, 32'h22,        0, 1, 1, 1, 2, 32'h22));
    vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 32'h12345678,  0, 0, 0,             1, 0, 1, 1, 3, 32'h12345678));
    vecs.push_back(mk(0, 1, 4, 32'h44,        0, 0, 0,             1, 0, 1, 1, 4, 32'h44));
    vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,             1, 0, 32'hFFFFFFFF,  0, 1, 0, 1, 0, 32'hFFFFFFFF));
    vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0, 5'd0, 5'd0));
    vecs.push_back(mk(1, 1, 7, 32'h77,        0, 0, 0,             1, 0, 0, 1, 7, 32'h77));
    vecs.push_back(mk(1, 0, 0, 0,             1, 8, 32'h88,        0, 0, 0, 1, 7, 32'h77));
    vecs.push_back(mk(1, 0, 0, 0,             1, 8, 32'h88,        0, 0, 0, 1, 7, 32'h77));
    vecs.push_back(mk(0, 0, 0, 0,             1, 8, 32'h88,        0, 0, 1, 1, 7, 32'h77));
    vecs.push_back(mk(0, 0, 0, 0,             1, 8, 32'h88,        0, 1, 1, 1, 8, 32'h88));
    vecs.push_back(mk(0, 1, 9, 32'hCAFEF00D,  1, 10, 32'h1010,     1, 0, 1, 1, 9, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0, 5'd9, 5'd9,
                      BYP ? 32'hCAFEF00D : RF_A, BYP ? 32'hCAFEF00D : RF_B));
    vecs.push_back(mk(0, 1, 11, 32'h0B,       1, 10, 32'h1010,     0, 1, 1, 1, 10, 32'h1010));
    vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,             0, 0, 0, 0, 0, 0));

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset RegWEn", {31'd0, RegWEn}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset AddrD", {27'd0, AddrD}, 32'd0);
    chk("reset DataD", DataD, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Asynchronous reset while a write to x5 sits in HOLD
    wr_hold = 1'b1; req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    req1_valid = 1'b0; AddrA = 5'd5; AddrB = 5'd31;
    #1 chk("rsthold req0_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    chk("rsthold busy", {31'd0, busy}, 32'd1);
    chk("rsthold RegWEn", {31'd0, RegWEn}, 32'd0);
    chk("rsthold AddrD", {27'd0, AddrD}, 32'd5);
    req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset RegWEn", {31'd0, RegWEn}, 32'd0);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset AddrD", {27'd0, AddrD}, 32'd0);
    chk("midreset DataD", DataD, 32'd0);
    chk("midreset DataA", DataA, RF_A);
    @(negedge clk);
    rst_n = 1'b1; wr_hold = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("postreset%0d busy", k), {31'd0, busy}, 32'd0);
      chk($sformatf("postreset%0d RegWEn", k), {31'd0, RegWEn}, 32'd0);
    end
    chk("sb drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
